// File: rtl/delay_interval_meter.sv
// Start/stop interval meter: a saturating up-counter timed between a start
// and a stop event, with an optional timeout. The result is held for the
// host on a valid/ready handshake.
module delay_interval_meter #(
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] timeout,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             timed_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COUNTING,
        S_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             tmo_q, tmo_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] cnt_inc;

    assign cnt_inc = cnt_q + WIDTH'(1);

    // Next-state and result logic; priority in COUNTING is stop, timeout, saturation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        limit_d  = limit_q;
        result_d = result_q;
        tmo_d    = tmo_q;
        ovf_d    = ovf_q;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (start) begin
                        tmo_d   = 1'b0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                        limit_d = timeout;
                        if (stop) begin
                            result_d = '0;
                            state_d  = S_HOLD;
                        end else begin
                            state_d  = S_COUNTING;
                        end
                    end
                end
                S_COUNTING: begin
                    cnt_d = cnt_inc;
                    if (stop) begin
                        result_d = cnt_inc;
                        state_d  = S_HOLD;
                    end else if ((limit_q != '0) && (cnt_inc == limit_q)) begin
                        result_d = limit_q;
                        tmo_d    = 1'b1;
                        state_d  = S_HOLD;
                    end else if (cnt_inc == '1) begin
                        result_d = '1;
                        ovf_d    = 1'b1;
                        state_d  = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = arm ? S_ARMED : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            limit_q  <= '0;
            result_q <= '0;
            tmo_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            limit_q  <= limit_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            ovf_q    <= ovf_d;
        end
    end

    assign q         = result_q;
    assign timed_out = tmo_q;
    assign overflow  = ovf_q;
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_ARMED) || (state_q == S_COUNTING);

endmodule

// File: doc/delay_interval_meter.md
# delay_interval_meter

Measures the interval between a start event and a stop event in master-clock cycles, using a 48-bit up-counter. It is the measuring counterpart to the loadable 48-bit countdown delay generator. Its main use is to verify generated delays in-system and to time-tag external trigger-to-response intervals. Results go out on a valid/ready handshake toward the host readout FIFO.

## Interface
Parameters:
- WIDTH, 48, counter and result width; matches the delay generator load width.

Ports:
- clk  input  1  master clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- arm  input  1  single-cycle request to arm for one measurement.
- abort  input  1  synchronous abort; forces IDLE from any state.
- start  input  1  start event; synchronous, sampled each clk.
- stop  input  1  stop event; synchronous, sampled each clk.
- timeout  input  WIDTH  interval limit in cycles; 0 disables the limit. Sampled when start is accepted.
- q  output  WIDTH  measured interval; holds the last result.
- out_valid  output  1  q holds an unconsumed result.
- out_ready  input  1  consumer accepts q on a cycle where out_valid=1 and out_ready=1.
- busy  output  1  high in ARMED or COUNTING.
- timed_out  output  1  the last result ended by timeout.
- overflow  output  1  the last result saturated at 2^WIDTH-1.

## Operation
States:
- **IDLE**
  - arm=1 → ARMED.
- **ARMED**
  - start=1 → COUNTING; cnt←0; the timeout value is latched.
  - start=1 and stop=1 in the same cycle → HOLD with q=0.
  - stop while ARMED is ignored.
- **COUNTING**
  - cnt←cnt+1 every cycle.
  - stop=1 → q←cnt+1, → HOLD.
  - When the latched timeout≠0 and cnt+1 equals the latched timeout without stop → q←timeout, timed_out←1, → HOLD.
  - If stop and the timeout match occur in the same cycle, stop wins and timed_out=0.
  - When cnt+1 would wrap → q←all ones, overflow←1, → HOLD.
  - Further start pulses are ignored.
- **HOLD**
  - out_valid=1.
  - On handshake → IDLE, or ARMED if arm=1 in the same cycle.
  - q, timed_out and overflow keep their values after the handshake until the next result is written.
  - arm, start and stop are ignored in HOLD unless the handshake occurs that cycle.

Further rules:
- abort from any state → IDLE; out_valid←0. q and the flags are unchanged.
- Result semantics: start sampled at edge N and stop sampled at edge N+k gives q=k.
- timed_out and overflow are cleared when start is accepted.
- Arithmetic is unsigned. cnt never wraps; it saturates.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, cnt=0.
  - q=0, out_valid=0, busy=0, timed_out=0, overflow=0.
- Arm to armed: busy rises the cycle after arm is sampled.
- Result latency: out_valid and the new q appear 1 cycle after the edge that samples stop, the timeout match, or saturation. busy falls on the same cycle.
- out_valid stays high until the handshake, for any number of out_ready=0 cycles.
- Re-measure: the earliest next start is accepted 1 cycle after the handshake, provided arm came with out_ready. Otherwise it is accepted 1 cycle after arm.
- Reset mid-COUNTING drops the measurement immediately, with no output event.
- Back-to-back delay generator test: if the delay generator loads l and the meter starts on the same edge, its thresh0 is used as stop. The required q is then the generator's documented load-to-thresh0 cycle count; the bench checks it against the generator model.

## Test plan
- Basic interval: arm; start at cycle 10; stop at cycle 25 → q=15, out_valid at cycle 26, timed_out=0, overflow=0.
- Start and stop in the same cycle while ARMED → q=0, out_valid on the next cycle.
- Timeout: timeout=100 and no stop → q=100, timed_out=1. Repeat with stop in the matching cycle → q=100, timed_out=0.
- Backpressure: hold out_ready=0 for 20 cycles after a result; stop and start pulses in that window are ignored. Then assert out_ready with arm → ARMED, and the next start is accepted.
- Saturation: WIDTH=8 instance, timeout=0, no stop → q=255, overflow=1, at start+255 cycles.
- Abort in COUNTING and reset_n low in COUNTING → IDLE, no out_valid pulse, busy=0. After reset, q and all flags read 0.
